riscv_pcctrl: RTL and testbench

Next-PC sequencer for the fetch stage. It drives the PC register's next-PC and stall inputs. It chooses between sequential fetch (+2 or +4 for RV64IMC), branch/jump redirects, trap entry and mret return. Redirects that arrive while fetch is stalled are held in a pending register and replayed once the stall clears. A boot counter holds the PC at its reset vector for a fixed number of cycles after reset.

---
 rtl/riscv_pcctrl_if.sv | 35 +++
 rtl/riscv_pcctrl.sv | 125 ++++++++++++
 tb/tb_riscv_pcctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pcctrl_if.sv
// Signal bundle between the fetch/EX pipeline (master) and the next-PC sequencer (slave).
// Signal names match the sequencer's published port list.
interface riscv_pcctrl_if;
   logic        i_riscv_pcctrl_stall;
   logic [63:0] i_riscv_pcctrl_pc;
   logic        i_riscv_pcctrl_compressed;
   logic        i_riscv_pcctrl_branch_valid;
   logic [63:0] i_riscv_pcctrl_branch_target;
   logic        i_riscv_pcctrl_trap_valid;
   logic [63:0] i_riscv_pcctrl_trap_target;
   logic        i_riscv_pcctrl_mret_valid;
   logic [63:0] i_riscv_pcctrl_mepc;
   logic [63:0] o_riscv_pcctrl_nextpc;
   logic        o_riscv_pcctrl_stallpc;
   logic        o_riscv_pcctrl_flush;
   logic        o_riscv_pcctrl_pending;

   modport master (
      output i_riscv_pcctrl_stall, i_riscv_pcctrl_pc, i_riscv_pcctrl_compressed,
             i_riscv_pcctrl_branch_valid, i_riscv_pcctrl_branch_target,
             i_riscv_pcctrl_trap_valid, i_riscv_pcctrl_trap_target,
             i_riscv_pcctrl_mret_valid, i_riscv_pcctrl_mepc,
      input  o_riscv_pcctrl_nextpc, o_riscv_pcctrl_stallpc,
             o_riscv_pcctrl_flush, o_riscv_pcctrl_pending
   );

   modport slave (
      input  i_riscv_pcctrl_stall, i_riscv_pcctrl_pc, i_riscv_pcctrl_compressed,
             i_riscv_pcctrl_branch_valid, i_riscv_pcctrl_branch_target,
             i_riscv_pcctrl_trap_valid, i_riscv_pcctrl_trap_target,
             i_riscv_pcctrl_mret_valid, i_riscv_pcctrl_mepc,
      output o_riscv_pcctrl_nextpc, o_riscv_pcctrl_stallpc,
             o_riscv_pcctrl_flush, o_riscv_pcctrl_pending
   );
endinterface

// File: rtl/riscv_pcctrl.sv
// Next-PC sequencer: sequential fetch, prioritised redirects (trap > mret > branch),
// a pending register that replays redirects seen during a stall, and a boot hold counter.
module riscv_pcctrl #(
   parameter int unsigned BOOT_CYCLES = 2
) (
   input  logic              i_riscv_pcctrl_clk,
   input  logic              i_riscv_pcctrl_rst_n,
   riscv_pcctrl_if.slave     bus
);

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_PEND} state_e;
   typedef enum logic [1:0] {PRIO_NONE, PRIO_BRANCH, PRIO_MRET, PRIO_TRAP} prio_e;

   localparam logic [3:0] BOOT_LOAD = 4'(BOOT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  boot_cnt_q, boot_cnt_d;
   prio_e       pend_prio_q, pend_prio_d;
   logic [63:0] pend_target_q, pend_target_d;

   prio_e       new_prio;
   logic [63:0] new_target;
   logic [63:0] seq_pc;
   logic        take_new;
   logic [63:0] nextpc;
   logic        stallpc;
   logic        flush;

   // Highest-priority incoming redirect; IALIGN=16 so only bit 0 is cleared.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      new_prio   = PRIO_NONE;
      new_target = '0;
      if (bus.i_riscv_pcctrl_trap_valid) begin
         new_prio   = PRIO_TRAP;
         new_target = bus.i_riscv_pcctrl_trap_target;
      end else if (bus.i_riscv_pcctrl_mret_valid) begin
         new_prio   = PRIO_MRET;
         new_target = bus.i_riscv_pcctrl_mepc;
      end else if (bus.i_riscv_pcctrl_branch_valid) begin
         new_prio   = PRIO_BRANCH;
         new_target = bus.i_riscv_pcctrl_branch_target;
      end
      new_target[0] = 1'b0;
   end

   assign seq_pc = bus.i_riscv_pcctrl_pc +
                   (bus.i_riscv_pcctrl_compressed ? 64'd2 : 64'd4);

   // A younger branch replaces a held branch; anything else must strictly outrank it.
   assign take_new = (new_prio > pend_prio_q) ||
                     (new_prio == PRIO_BRANCH && pend_prio_q == PRIO_BRANCH);

   always_comb begin
      state_d       = state_q;
      boot_cnt_d    = boot_cnt_q;
      pend_prio_d   = pend_prio_q;
      pend_target_d = pend_target_q;
      nextpc        = seq_pc;
      stallpc       = 1'b1;
      flush         = 1'b0;

      unique case (state_q)
         ST_BOOT: begin
            if (boot_cnt_q == 4'd0) state_d    = ST_RUN;
            else                    boot_cnt_d = boot_cnt_q - 4'd1;
         end

         ST_RUN: begin
            if (bus.i_riscv_pcctrl_stall) begin
               if (new_prio != PRIO_NONE) begin
                  pend_prio_d   = new_prio;
                  pend_target_d = new_target;
                  state_d       = ST_PEND;
               end
            end else begin
               stallpc = 1'b0;
               if (new_prio != PRIO_NONE) begin
                  nextpc = new_target;
                  flush  = 1'b1;
               end
            end
         end

         ST_PEND: begin
            if (bus.i_riscv_pcctrl_stall) begin
               if (take_new) begin
                  pend_prio_d   = new_prio;
                  pend_target_d = new_target;
               end
            end else begin
               stallpc       = 1'b0;
               flush         = 1'b1;
               nextpc        = take_new ? new_target : pend_target_q;
               pend_prio_d   = PRIO_NONE;
               pend_target_d = '0;
               state_d       = ST_RUN;
            end
         end

         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge i_riscv_pcctrl_clk or negedge i_riscv_pcctrl_rst_n) begin
      if (!i_riscv_pcctrl_rst_n) begin
         state_q       <= ST_BOOT;
         boot_cnt_q    <= BOOT_LOAD;
         pend_prio_q   <= PRIO_NONE;
         pend_target_q <= '0;
      end else begin
         // NOTE: non-blocking so every register updates from the same pre-edge values.
         state_q       <= state_d;
         boot_cnt_q    <= boot_cnt_d;
         pend_prio_q   <= pend_prio_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign bus.o_riscv_pcctrl_nextpc  = nextpc;
   assign bus.o_riscv_pcctrl_stallpc = stallpc;
   assign bus.o_riscv_pcctrl_flush   = flush;
   assign bus.o_riscv_pcctrl_pending = (state_q == ST_PEND);

endmodule

// File: tb/tb_riscv_pcctrl.sv
// Scoreboard bench for riscv_pcctrl: each cycle pushes its expected outputs,
// then pops and compares them mid-cycle, away from the rising edge.
module tb_riscv_pcctrl;

   logic clk;
   logic rst_n;

   riscv_pcctrl_if bus ();

   riscv_pcctrl #(.BOOT_CYCLES(2)) dut (
      .i_riscv_pcctrl_clk   (clk),
      .i_riscv_pcctrl_rst_n (rst_n),
      .bus                  (bus)
   );

   typedef struct {
      string       tag;
      bit          chk_pc;
      logic [63:0] nextpc;
      logic        stallpc;
      logic        flush;
      logic        pending;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input bit chk_pc, input logic [63:0] pc,
                           input logic st, input logic fl, input logic pd);
      exp_t e;
      e.tag = tag; e.chk_pc = chk_pc; e.nextpc = pc;
      e.stallpc = st; e.flush = fl; e.pending = pd;
      sb_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 64'd1, 64'd0);
         return;
      end
      e = sb_q.pop_front();
      if (e.chk_pc) check({e.tag, ".nextpc"}, bus.o_riscv_pcctrl_nextpc, e.nextpc);
      check({e.tag, ".stallpc"}, {63'd0, bus.o_riscv_pcctrl_stallpc}, {63'd0, e.stallpc});
      check({e.tag, ".flush"},   {63'd0, bus.o_riscv_pcctrl_flush},   {63'd0, e.flush});
      check({e.tag, ".pending"}, {63'd0, bus.o_riscv_pcctrl_pending}, {63'd0, e.pending});
   endtask

   // Called at a falling edge: drive one cycle of inputs, check, advance to next falling edge.
   task automatic step(input string tag, input logic stall, input logic comp,
                       input logic br, input logic tr, input logic mr,
                       input bit chk_pc, input logic [63:0] exp_pc,
                       input logic exp_st, input logic exp_fl, input logic exp_pd);
      bus.i_riscv_pcctrl_stall        = stall;
      bus.i_riscv_pcctrl_compressed   = comp;
      bus.i_riscv_pcctrl_branch_valid = br;
      bus.i_riscv_pcctrl_trap_valid   = tr;
      bus.i_riscv_pcctrl_mret_valid   = mr;
      push_exp(tag, chk_pc, exp_pc, exp_st, exp_fl, exp_pd);
      #2;
      compare_out();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [63:0] PC0 = 64'h0000_0000_8000_0062;

   initial begin
      rst_n = 1'b0;
      bus.i_riscv_pcctrl_stall        = 1'b0;
      bus.i_riscv_pcctrl_pc           = PC0;
      bus.i_riscv_pcctrl_compressed   = 1'b0;
      bus.i_riscv_pcctrl_branch_valid = 1'b0;
      bus.i_riscv_pcctrl_trap_valid   = 1'b0;
      bus.i_riscv_pcctrl_mret_valid   = 1'b0;
      bus.i_riscv_pcctrl_branch_target = 64'h8000_3001;
      bus.i_riscv_pcctrl_trap_target   = 64'h8000_1000;
      bus.i_riscv_pcctrl_mepc          = 64'h8000_2000;

      #3;
      push_exp("in_reset", 0, '0, 1, 0, 0);
      compare_out();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Boot hold: two stalled cycles, a branch during BOOT is ignored.
      step("boot0",        0, 0, 0, 0, 0, 0, '0, 1, 0, 0);
      step("boot1_br_ign", 0, 0, 1, 0, 0, 0, '0, 1, 0, 0);
      step("run_seq4",     0, 0, 0, 0, 0, 1, 64'h8000_0066, 0, 0, 0);
      step("run_seq2",     0, 1, 0, 0, 0, 1, 64'h8000_0064, 0, 0, 0);

      // Priority with no stall.
      step("prio_all",     0, 0, 1, 1, 1, 1, 64'h8000_1000, 0, 1, 0);
      step("prio_after",   0, 0, 0, 0, 0, 1, 64'h8000_0066, 0, 0, 0);
      step("prio_mret_br", 0, 0, 1, 0, 1, 1, 64'h8000_2000, 0, 1, 0);
      step("prio_br",      0, 0, 1, 0, 0, 1, 64'h8000_3000, 0, 1, 0);

      // Stalled branch held for three stall cycles then replayed.
      bus.i_riscv_pcctrl_branch_target = 64'h8000_4000;
      step("stb_cap",   1, 0, 1, 0, 0, 0, '0, 1, 0, 0);
      step("stb_hold1", 1, 0, 0, 0, 0, 0, '0, 1, 0, 1);
      step("stb_hold2", 1, 0, 0, 0, 0, 0, '0, 1, 0, 1);
      step("stb_rel",   0, 0, 0, 0, 0, 1, 64'h8000_4000, 0, 1, 1);
      step("stb_done",  0, 0, 0, 0, 0, 1, 64'h8000_0066, 0, 0, 0);

      // Pending override by trap; later mret and branch are dropped.
      bus.i_riscv_pcctrl_branch_target = 64'h8000_6000;
      bus.i_riscv_pcctrl_trap_target   = 64'h8000_5000;
      bus.i_riscv_pcctrl_mepc          = 64'h8000_7000;
      step("ovr_cap_br",  1, 0, 1, 0, 0, 0, '0, 1, 0, 0);
      step("ovr_trap",    1, 0, 0, 1, 0, 0, '0, 1, 0, 1);
      step("ovr_mret_dr", 1, 0, 0, 0, 1, 0, '0, 1, 0, 1);
      step("ovr_br_dr",   1, 0, 1, 0, 0, 0, '0, 1, 0, 1);
      step("ovr_rel",     0, 0, 0, 0, 0, 1, 64'h8000_5000, 0, 1, 1);
      step("ovr_done",    0, 0, 0, 0, 0, 1, 64'h8000_0066, 0, 0, 0);

      // Youngest branch wins over a held branch.
      bus.i_riscv_pcctrl_branch_target = 64'h8000_8000;
      step("ybr_cap", 1, 0, 1, 0, 0, 0, '0, 1, 0, 0);
      bus.i_riscv_pcctrl_branch_target = 64'h8000_A000;
      step("ybr_new", 1, 0, 1, 0, 0, 0, '0, 1, 0, 1);
      step("ybr_rel", 0, 0, 0, 0, 0, 1, 64'h8000_A000, 0, 1, 1);

      // Trap arriving on the release cycle beats the held branch; bit 0 cleared, bit 1 kept.
      bus.i_riscv_pcctrl_branch_target = 64'h8000_C000;
      bus.i_riscv_pcctrl_trap_target   = 64'h8000_D003;
      step("rtr_cap",  1, 0, 1, 0, 0, 0, '0, 1, 0, 0);
      step("rtr_rel",  0, 0, 0, 1, 0, 1, 64'h8000_D002, 0, 1, 1);
      step("rtr_done", 0, 1, 0, 0, 0, 1, 64'h8000_0064, 0, 0, 0);

      // 64-bit wrap-around of the sequential PC.
      bus.i_riscv_pcctrl_pc = 64'hFFFF_FFFF_FFFF_FFFE;
      step("wrap4", 0, 0, 0, 0, 0, 1, 64'h2, 0, 0, 0);
      step("wrap2", 0, 1, 0, 0, 0, 1, 64'h0, 0, 0, 0);
      bus.i_riscv_pcctrl_pc = PC0;

      // Asynchronous reset while PEND.
      bus.i_riscv_pcctrl_branch_target = 64'h8000_4000;
      step("ar_cap",  1, 0, 1, 0, 0, 0, '0, 1, 0, 0);
      step("ar_pend", 1, 0, 0, 0, 0, 0, '0, 1, 0, 1);
      #1 rst_n = 1'b0;
      bus.i_riscv_pcctrl_stall = 1'b0;
      #1;
      push_exp("ar_async", 0, '0, 1, 0, 0);
      compare_out();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step("ar_boot0", 0, 0, 0, 0, 0, 0, '0, 1, 0, 0);
      step("ar_boot1", 0, 0, 0, 0, 0, 0, '0, 1, 0, 0);
      step("ar_run",   0, 0, 0, 0, 0, 1, 64'h8000_0066, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
